// File: rtl/cp_symbol_tx.sv
// cp_symbol_tx: CP-framed OFDM symbol source for the timing/CFO estimator.
//
// Collects N complex samples into a buffer. It then emits one frame: an
// optional leading run of zero samples (first symbol after reset only),
// then the cyclic prefix buf[N-CP_LEN..N-1], then the body buf[0..N-1].
// The emission path is two registers deep: a registered buffer read
// followed by the output register. The first frame sample therefore
// appears two cycles after the edge that accepts sample N-1.
//
// Optional feature, compile-time macro CP_TX_DITHER_EN: a 16-bit Fibonacci
// LFSR (seed 16'hACE1) adds +/-1 LSB of dither to every valid output sample.
// Bit 0 applies to re and bit 1 to img, with saturation.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  source handshake; samples offered while busy are dropped
//   in_re, in_img      source sample, signed Q1.15
//   rho_in             SNR weight, latched on each symbol's first sample
//   theta_cfg          leading zero-sample count, latched once after reset
//   out_valid          estimator in_valid
//   out_re, out_img    estimator rx_re_in / rx_img_in
//   rho_out            estimator rho, updated on sym_start
//   sym_start          pulse on the first CP sample of each symbol
module cp_symbol_tx #(
    parameter int N      = 64,
    parameter int CP_LEN = 16,
    parameter int W      = 16,
    parameter int RHO_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_re,
    input  logic [W-1:0]     in_img,
    input  logic [RHO_W-1:0] rho_in,
    input  logic [7:0]       theta_cfg,
    output logic             out_valid,
    output logic [W-1:0]     out_re,
    output logic [W-1:0]     out_img,
    output logic [RHO_W-1:0] rho_out,
    output logic             sym_start
);

    localparam int AW = $clog2(N);
    // One counter serves as the write address, offset count, CP index and body index.
    localparam int CW = (AW > 8) ? AW : 8;

    typedef enum logic [1:0] {FILL, OFFSET, CP, BODY} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            first_sym, first_sym_nxt;
    logic [7:0]      theta_lat;
    logic [RHO_W-1:0] rho_lat;

    logic            accept;
    logic            emit, emit_zero, emit_start;
    logic [AW-1:0]   rd_addr;

    logic [2*W-1:0]  mem [N];
    logic [2*W-1:0]  rd_data;
    logic            s1_valid, s1_zero, s1_start;
    logic [W-1:0]    s1_re, s1_img;

    assign in_ready = (state == FILL);
    assign accept   = in_valid && in_ready;

    // ---------------- control: next state and emission request ----------
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_nxt     = state;
        cnt_nxt       = cnt;
        first_sym_nxt = first_sym;
        emit          = 1'b0;
        emit_zero     = 1'b0;
        emit_start    = 1'b0;
        rd_addr       = '0;
        case (state)
            FILL: begin
                if (accept) begin
                    if (cnt == CW'(N - 1)) begin
                        cnt_nxt       = '0;
                        first_sym_nxt = 1'b0;
                        state_nxt     = (first_sym && theta_lat != 8'd0) ? OFFSET : CP;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            OFFSET: begin
                emit      = 1'b1;
                emit_zero = 1'b1;
                if (cnt == CW'(theta_lat) - CW'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = CP;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            CP: begin
                emit       = 1'b1;
                emit_start = (cnt == '0);
                // AW-bit truncation makes the address wrap mod N.
                rd_addr    = AW'(N - CP_LEN) + cnt[AW-1:0];
                if (cnt == CW'(CP_LEN - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = BODY;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            BODY: begin
                emit    = 1'b1;
                rd_addr = cnt[AW-1:0];
                if (cnt == CW'(N - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = FILL;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            cnt       <= '0;
            first_sym <= 1'b1;
            theta_lat <= 8'd0;
            rho_lat   <= '0;
            s1_valid  <= 1'b0;
            s1_zero   <= 1'b0;
            s1_start  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            first_sym <= first_sym_nxt;
            if (accept && cnt == '0) begin
                rho_lat <= rho_in;
                if (first_sym) theta_lat <= theta_cfg;
            end
            s1_valid <= emit;
            s1_zero  <= emit_zero;
            s1_start <= emit_start;
        end
    end

    // ---------------- single-port sample buffer -------------------------
    // NOTE: the buffer and its read register have no reset; s1_valid and
    // s1_zero gate whatever stale data they hold.
    always_ff @(posedge clk) begin
        if (accept) mem[cnt[AW-1:0]] <= {in_re, in_img};
        if (emit)   rd_data <= mem[rd_addr];
    end

    assign s1_re  = s1_zero ? '0 : rd_data[2*W-1:W];
    assign s1_img = s1_zero ? '0 : rd_data[W-1:0];

    // ---------------- output register -----------------------------------
`ifdef CP_TX_DITHER_EN
    localparam logic [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONE   = W'(1);

    logic [15:0] lfsr;

    function automatic logic [W-1:0] dither(input logic [W-1:0] x, input logic up);
        if (up) return (x == S_MAX) ? x : x + ONE;
        return (x == S_MIN) ? x : x - ONE;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (s1_valid) begin
            // Taps 16,14,13,11 in right-shift form.
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_re    <= '0;
            out_img   <= '0;
            rho_out   <= '0;
            sym_start <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            out_re    <= s1_valid ? dither(s1_re, lfsr[0])  : '0;
            out_img   <= s1_valid ? dither(s1_img, lfsr[1]) : '0;
            sym_start <= s1_start;
            if (s1_start) rho_out <= rho_lat;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_re    <= '0;
            out_img   <= '0;
            rho_out   <= '0;
            sym_start <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            out_re    <= s1_valid ? s1_re  : '0;
            out_img   <= s1_valid ? s1_img : '0;
            sym_start <= s1_start;
            if (s1_start) rho_out <= rho_lat;
        end
    end
`endif

endmodule

// File: tb/tb_cp_symbol_tx.sv
// Testbench for cp_symbol_tx. A frame-level model predicts the cycle on
// which each output sample appears, along with in_ready, rho_out and
// sym_start. Every output is compared on the falling edge.
module tb_cp_symbol_tx;

    localparam int N      = 64;
    localparam int CP_LEN = 16;
    localparam int W      = 16;
    localparam int RHO_W  = 8;

    logic             clk, rst;
    logic             in_valid, in_ready;
    logic [W-1:0]     in_re, in_img;
    logic [RHO_W-1:0] rho_in;
    logic [7:0]       theta_cfg;
    logic             out_valid, sym_start;
    logic [W-1:0]     out_re, out_img;
    logic [RHO_W-1:0] rho_out;

    cp_symbol_tx #(.N(N), .CP_LEN(CP_LEN), .W(W), .RHO_W(RHO_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_img(in_img),
        .rho_in(rho_in), .theta_cfg(theta_cfg),
        .out_valid(out_valid), .out_re(out_re), .out_img(out_img),
        .rho_out(rho_out), .sym_start(sym_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model -----------------------------------
    typedef struct {
        longint     at;
        logic [W-1:0] re, im;
        logic       start;
        logic [RHO_W-1:0] rho;
    } exp_t;

    exp_t             exp_q[$];
    logic [W-1:0]     sb_re[N], sb_im[N];
    int               fill_cnt;
    bit               first_sym_m;
    logic [7:0]       theta_m;
    logic [RHO_W-1:0] rho_m, exp_rho;
    longint           busy_end;
    int               syms_done = 0;
    logic [15:0]      lf;

    task automatic model_reset();
        exp_q.delete();
        fill_cnt    = 0;
        first_sym_m = 1'b1;
        theta_m     = '0;
        rho_m       = '0;
        exp_rho     = '0;
        busy_end    = cyc;
        lf          = 16'hACE1;
    endtask

    // Sample accepted on clock edge number 'at'. When the symbol is
    // complete, the whole frame is scheduled starting two edges later.
    task automatic model_accept(input logic [W-1:0] re, input logic [W-1:0] im,
                                input logic [RHO_W-1:0] rho, input logic [7:0] theta,
                                input longint at);
        int th;
        longint t;
        exp_t e;
        if (fill_cnt == 0) begin
            rho_m = rho;
            if (first_sym_m) theta_m = theta;
        end
        sb_re[fill_cnt] = re;
        sb_im[fill_cnt] = im;
        fill_cnt++;
        if (fill_cnt == N) begin
            th = first_sym_m ? int'(theta_m) : 0;
            first_sym_m = 1'b0;
            t = at + 2;
            for (int i = 0; i < th; i++) begin
                e = '{at: t, re: '0, im: '0, start: 1'b0, rho: rho_m};
                exp_q.push_back(e); t++;
            end
            for (int i = 0; i < CP_LEN; i++) begin
                e = '{at: t, re: sb_re[N-CP_LEN+i], im: sb_im[N-CP_LEN+i],
                      start: (i == 0), rho: rho_m};
                exp_q.push_back(e); t++;
            end
            for (int i = 0; i < N; i++) begin
                e = '{at: t, re: sb_re[i], im: sb_im[i], start: 1'b0, rho: rho_m};
                exp_q.push_back(e); t++;
            end
            busy_end = at + th + CP_LEN + N;
            fill_cnt = 0;
            syms_done++;
        end
    endtask

`ifdef CP_TX_DITHER_EN
    function automatic logic [W-1:0] sat_step(input logic [W-1:0] x, input logic up);
        if (up) return (x == 16'h7FFF) ? x : x + 16'd1;
        return (x == 16'h8000) ? x : x - 16'd1;
    endfunction
`endif

    // Compares all outputs for the current edge against the schedule.
    task automatic monitor();
        exp_t e;
        logic [W-1:0] er, ei;
        if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
            e = exp_q.pop_front();
            er = e.re;
            ei = e.im;
`ifdef CP_TX_DITHER_EN
            er = sat_step(e.re, lf[0]);
            ei = sat_step(e.im, lf[1]);
            lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
`endif
            if (e.start) exp_rho = e.rho;
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_re",    32'(out_re),    32'(er));
            check("out_img",   32'(out_img),   32'(ei));
            check("sym_start", 32'(sym_start), 32'(e.start));
        end else begin
            check("idle_valid", 32'(out_valid), 32'd0);
            check("idle_re",    32'(out_re),    32'd0);
            check("idle_img",   32'(out_img),   32'd0);
            check("idle_start", 32'(sym_start), 32'd0);
        end
        check("rho_out", 32'(rho_out), 32'(exp_rho));
    endtask

    // One clock: at the falling edge, check in_ready and drive inputs.
    // Then wait for the rising edge and check outputs at the next falling edge.
    task automatic tick(input logic v, input logic [W-1:0] re, input logic [W-1:0] im,
                        input logic [RHO_W-1:0] rho, input logic [7:0] theta);
        logic rdy;
        rdy = (cyc + 1 > busy_end);
        check("in_ready", 32'(in_ready), 32'(rdy));
        in_valid  = v;
        in_re     = re;
        in_img    = im;
        rho_in    = rho;
        theta_cfg = theta;
        if (v && rdy) model_accept(re, im, rho, theta, cyc + 1);
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    // mode 0: random data, 1: ramp re=k img=-k, 2: full-scale constants
    task automatic send_symbol(input logic [RHO_W-1:0] rho, input logic [7:0] theta,
                               input int mode, input int gap_pct);
        int target, guard, k;
        logic v;
        logic [W-1:0] re, im;
        target = syms_done + 1;
        guard  = 0;
        while (syms_done < target && guard < 3000) begin
            v = ($urandom_range(99) >= gap_pct);
            k = fill_cnt;
            case (mode)
                1:       begin re = W'(k);     im = W'(-k);     end
                2:       begin re = 16'h7FFF;  im = 16'h8000;   end
                default: begin re = W'($urandom); im = W'($urandom); end
            endcase
            tick(v, re, im, rho, theta);
            guard++;
        end
        check("symbol_accepted", 32'(syms_done >= target), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, W'($urandom), W'($urandom), rho_in, theta_cfg);
    endtask

    // Asserts reset between clock edges and checks that it takes effect immediately.
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_re",    32'(out_re),    32'd0);
        check("rst_img",   32'(out_img),   32'd0);
        check("rst_rho",   32'(rho_out),   32'd0);
        check("rst_start", 32'(sym_start), 32'd0);
        check("rst_ready", 32'(in_ready),  32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_re = '0; in_img = '0; rho_in = '0; theta_cfg = '0;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_ready", 32'(in_ready),  32'd1);
        check("reset_rho",   32'(rho_out),   32'd0);
        rst = 1'b0;
        model_reset();

        // theta 0: ramp symbol, then back-to-back symbols with in_valid held high
        send_symbol(8'h40, 8'd0, 1, 0);
        send_symbol(8'h20, 8'd9, 0, 0);
        send_symbol(8'h5A, 8'd9, 0, 30);
        idle(N + CP_LEN + 10);

        // theta 5 on the first symbol only; a later theta change is ignored
        mid_reset();
        send_symbol(8'h40, 8'd5, 0, 0);
        send_symbol(8'h20, 8'd9, 2, 20);
        idle(N + CP_LEN + 10);

        // reset while body sample 30 is on the output, then the offset is reapplied
        mid_reset();
        send_symbol(8'h33, 8'd3, 0, 0);
        idle(3 + CP_LEN + 32);
        mid_reset();
        send_symbol(8'h11, 8'd7, 0, 10);
        idle(N + CP_LEN + 12);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
